// File: rtl/cnn_pkg.sv
// cnn_pkg: types and width defaults shared by the CNN accelerator layers
// (pooling mode, pool FSM states, data/address width defaults).
package cnn_pkg;

  localparam int unsigned CNN_DATA_WIDTH = 16;
  localparam int unsigned CNN_ADDR_WIDTH = 20;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [2:0] {
    PS_IDLE   = 3'd0,
    PS_RD_REQ = 3'd1,
    PS_ACC    = 3'd2,
    PS_WR_REQ = 3'd3,
    PS_NEXT   = 3'd4,
    PS_FIN    = 3'd5
  } pool_state_e;

endpackage

// File: rtl/pool_window_acc.sv
// pool_window_acc: per-window max/sum accumulator with average shift and
// optional ReLU clamp on the result (enabled by POOL_RELU_EN).
module pool_window_acc
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int unsigned WIN        = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_acc_en,
  input  logic                         i_first,
  input  pool_mode_e                   i_mode,
  input  logic signed [DATA_WIDTH-1:0] i_pix,
  output logic signed [DATA_WIDTH-1:0] o_result
);

  localparam int unsigned SHIFT = 2 * $clog2(WIN);
  localparam int unsigned ACC_W = DATA_WIDTH + SHIFT;

  logic signed [ACC_W-1:0]      r_acc;
  logic signed [ACC_W-1:0]      w_pix_ext;
  logic signed [ACC_W-1:0]      w_acc_n;
  logic signed [DATA_WIDTH-1:0] w_avg;
  logic signed [DATA_WIDTH-1:0] w_sel;

  assign w_pix_ext = ACC_W'(i_pix);

  // The first pixel of a window seeds the accumulator in both modes.
  always_comb begin
    w_acc_n = r_acc;
    if (i_first) begin
      w_acc_n = w_pix_ext;
    end else if (i_mode == POOL_AVG) begin
      w_acc_n = r_acc + w_pix_ext;
    end else if (w_pix_ext > r_acc) begin
      w_acc_n = w_pix_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= w_acc_n;
    end
  end

  // Dropping the low SHIFT bits of a signed sum is a floor division.
  assign w_avg = r_acc[ACC_W-1:SHIFT];
  assign w_sel = (i_mode == POOL_AVG) ? w_avg : r_acc[DATA_WIDTH-1:0];

`ifdef POOL_RELU_EN
  assign o_result = w_sel[DATA_WIDTH-1] ? '0 : w_sel;
`else
  assign o_result = w_sel;
`endif

endmodule

// File: rtl/pool_stream_engine.sv
// pool_stream_engine: streams WINxWIN windows (stride WIN) of img_count square
// maps over a req/ack port and writes max/avg results contiguously; POOL_RELU_EN adds ReLU.
module pool_stream_engine
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = CNN_ADDR_WIDTH,
  parameter int unsigned SIZE_WIDTH = 8,
  parameter int unsigned WIN        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [SIZE_WIDTH-1:0] img_count,
  input  logic [SIZE_WIDTH-1:0] img_size,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  output logic                  mem_req,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned WIN_LOG = $clog2(WIN);

  pool_state_e r_state, w_state_n;
  pool_mode_e  r_mode;

  logic [SIZE_WIDTH-1:0] r_count, r_size, r_osize;
  logic [ADDR_WIDTH-1:0] r_src, r_dst, r_out_idx;
  logic [WIN_LOG-1:0]    r_wx, r_wy, w_nwx, w_nwy;
  logic [SIZE_WIDTH-1:0] r_ox, r_oy, r_img, w_nox, w_noy, w_nimg;

  logic                  r_mem_req, r_mem_rw, r_busy, r_done;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic                         w_degenerate, w_last_win;
  logic                         w_last_ox, w_last_oy, w_last_img, w_last_out;
  logic [ADDR_WIDTH-1:0]        w_map_off, w_row, w_col, w_rd_addr;
  logic signed [DATA_WIDTH-1:0] w_result;

  assign w_degenerate = (img_count == '0) || (img_size < SIZE_WIDTH'(WIN));
  assign w_last_win   = (&r_wx) && (&r_wy);
  assign w_last_ox    = (r_ox == r_osize - 1'b1);
  assign w_last_oy    = (r_oy == r_osize - 1'b1);
  assign w_last_img   = (r_img == r_count - 1'b1);
  assign w_last_out   = w_last_ox && w_last_oy && w_last_img;

  // Position of the next read: next pixel of the window in ACC, first pixel
  // of the next output window in NEXT.
  always_comb begin
    w_nwx  = '0;
    w_nwy  = '0;
    w_nox  = r_ox;
    w_noy  = r_oy;
    w_nimg = r_img;
    if (r_state == PS_ACC) begin
      w_nwx = r_wx + 1'b1;
      w_nwy = (&r_wx) ? r_wy + 1'b1 : r_wy;
    end else if (w_last_ox) begin
      w_nox = '0;
      if (w_last_oy) begin
        w_noy  = '0;
        w_nimg = r_img + 1'b1;
      end else begin
        w_noy = r_oy + 1'b1;
      end
    end else begin
      w_nox = r_ox + 1'b1;
    end
  end

  assign w_map_off = ADDR_WIDTH'(w_nimg) * ADDR_WIDTH'(r_size) * ADDR_WIDTH'(r_size);
  assign w_row     = (ADDR_WIDTH'(w_noy) << WIN_LOG) + ADDR_WIDTH'(w_nwy);
  assign w_col     = (ADDR_WIDTH'(w_nox) << WIN_LOG) + ADDR_WIDTH'(w_nwx);
  assign w_rd_addr = r_src + w_map_off + w_row * ADDR_WIDTH'(r_size) + w_col;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      PS_IDLE:   if (start) w_state_n = w_degenerate ? PS_FIN : PS_RD_REQ;
      PS_RD_REQ: if (mem_ack) w_state_n = PS_ACC;
      PS_ACC:    w_state_n = w_last_win ? PS_WR_REQ : PS_RD_REQ;
      PS_WR_REQ: if (mem_ack) w_state_n = PS_NEXT;
      PS_NEXT:   w_state_n = w_last_out ? PS_FIN : PS_RD_REQ;
      PS_FIN:    w_state_n = PS_IDLE;
      default:   w_state_n = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= PS_IDLE;
    else        r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode      <= POOL_MAX;
      r_count     <= '0;
      r_size      <= '0;
      r_osize     <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_out_idx   <= '0;
      r_wx        <= '0;
      r_wy        <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_img       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_rw    <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        PS_IDLE: if (start) begin
          r_mode    <= pool_mode_e'(mode);
          r_count   <= img_count;
          r_size    <= img_size;
          r_osize   <= img_size >> WIN_LOG;
          r_src     <= src_addr;
          r_dst     <= dst_addr;
          r_out_idx <= '0;
          r_wx      <= '0;
          r_wy      <= '0;
          r_ox      <= '0;
          r_oy      <= '0;
          r_img     <= '0;
          r_busy    <= 1'b1;
          if (!w_degenerate) begin
            r_mem_req  <= 1'b1;
            r_mem_rw   <= 1'b1;
            r_mem_addr <= src_addr;
          end
        end
        PS_RD_REQ: if (mem_ack) r_mem_req <= 1'b0;
        PS_ACC: begin
          r_mem_req <= 1'b1;
          if (w_last_win) begin
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= r_dst + r_out_idx;
            r_mem_wdata <= w_result;
          end else begin
            r_wx       <= w_nwx;
            r_wy       <= w_nwy;
            r_mem_rw   <= 1'b1;
            r_mem_addr <= w_rd_addr;
          end
        end
        PS_WR_REQ: if (mem_ack) begin
          r_mem_req <= 1'b0;
          r_mem_rw  <= 1'b1;
          r_out_idx <= r_out_idx + 1'b1;
        end
        PS_NEXT: if (!w_last_out) begin
          r_wx       <= '0;
          r_wy       <= '0;
          r_ox       <= w_nox;
          r_oy       <= w_noy;
          r_img      <= w_nimg;
          r_mem_req  <= 1'b1;
          r_mem_addr <= w_rd_addr;
        end
        PS_FIN: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  pool_window_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIN        (WIN)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .i_acc_en ((r_state == PS_RD_REQ) && mem_ack),
    .i_first  ((r_wx == '0) && (r_wy == '0)),
    .i_mode   (r_mode),
    .i_pix    (mem_rdata),
    .o_result (w_result)
  );

  assign mem_req   = r_mem_req;
  assign mem_rw    = r_mem_rw;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pool_stream_engine.sv
// tb_pool_stream_engine: directed and randomized runs of pool_stream_engine
// against a memory model and a window-by-window reference computation.
module tb_pool_stream_engine;

  localparam int DW  = 16;
  localparam int AW  = 20;
  localparam int SW  = 8;
  localparam int WIN = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [SW-1:0] img_count = '0;
  logic [SW-1:0] img_size = '0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic          mem_req, mem_rw, mem_ack, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic signed [DW-1:0] mem [0:4095];

  int n_assert = 0;
  int n_fail   = 0;

  int max_delay = 0;
  int cur_delay = 0;
  int wcnt      = 0;
  bit hold_wr   = 1'b0;
  bit stray_en  = 1'b0;
  bit stray_bit = 1'b0;

  int unsigned          rq[$];
  int unsigned          wq_a[$];
  logic signed [DW-1:0] wq_d[$];
  int                   stab_err = 0;
  int                   req_cycles = 0;
  logic                 p_req = 1'b0, p_ack = 1'b0, p_rw = 1'b1;
  logic [AW-1:0]        p_addr = '0;
  logic [DW-1:0]        p_wd = '0;

  pool_stream_engine #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SIZE_WIDTH (SW),
    .WIN        (WIN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .img_count (img_count),
    .img_size  (img_size),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .mem_req   (mem_req),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:0]];
  assign mem_ack   = mem_req ? (!(hold_wr && !mem_rw) && (wcnt >= cur_delay))
                             : (stray_en && stray_bit);

  // Memory responder and protocol monitor.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt      <= 0;
      cur_delay <= 0;
      p_req     <= 1'b0;
      p_ack     <= 1'b0;
    end else begin
      stray_bit <= 1'($urandom_range(0, 1));
      if (mem_req) req_cycles <= req_cycles + 1;
      if (mem_req && mem_ack) begin
        if (mem_rw) rq.push_back(mem_addr);
        else begin
          wq_a.push_back(mem_addr);
          wq_d.push_back(mem_wdata);
        end
        wcnt      <= 0;
        cur_delay <= $urandom_range(0, max_delay);
      end else if (mem_req) begin
        wcnt <= wcnt + 1;
      end
      if ((p_req && !p_ack && (!mem_req || mem_addr !== p_addr || mem_rw !== p_rw ||
           mem_wdata !== p_wd)) || (p_req && p_ack && mem_req))
        stab_err <= stab_err + 1;
      p_req  <= mem_req;
      p_ack  <= mem_ack;
      p_rw   <= mem_rw;
      p_addr <= mem_addr;
      p_wd   <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run(input logic m, input int cnt, input int sz, input int src,
                     input int dst, output int cyc);
    @(negedge clk);
    mode = m; img_count = SW'(cnt); img_size = SW'(sz);
    src_addr = AW'(src); dst_addr = AW'(dst); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = ~m; img_count = SW'($urandom); img_size = SW'($urandom);
    src_addr = AW'($urandom); dst_addr = AW'($urandom);
    cyc = 1;
    chk("busy_rise", busy, 1);
    while (done !== 1'b1 && cyc < 20000) begin
      start = (cyc == 7);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("run_timeout", cyc < 20000, 1);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask

  task automatic check_run(input string tag, input logic m, input int cnt, input int sz,
                           input int src, input int dst, input int w0);
    int o, k, s, mx, v, n;
    n = WIN * WIN;
    o = sz / WIN;
    k = 0;
    chk({tag, "_nwrites"}, wq_a.size() - w0, cnt * o * o);
    for (int i = 0; i < cnt; i++)
      for (int oy = 0; oy < o; oy++)
        for (int ox = 0; ox < o; ox++) begin
          s  = 0;
          mx = -(1 << 30);
          for (int wy = 0; wy < WIN; wy++)
            for (int wx = 0; wx < WIN; wx++) begin
              v = mem[src + i * sz * sz + (oy * WIN + wy) * sz + ox * WIN + wx];
              s += v;
              if (v > mx) mx = v;
            end
          if (m) begin
            v = s / n;
            if (s < 0 && (s % n) != 0) v = v - 1;
          end else begin
            v = mx;
          end
`ifdef POOL_RELU_EN
          if (v < 0) v = 0;
`endif
          if (w0 + k < wq_a.size()) begin
            chk({tag, "_waddr"}, wq_a[w0 + k], dst + k);
            chk({tag, "_wdata"}, wq_d[w0 + k], v);
          end
          k++;
        end
  endtask

  initial begin
    int cyc, r0, w0, c0, s0, viol, cnt, sz, off;
    logic m;
    int exp_a[4];
    int exp_b[4];

    for (int j = 0; j < 4096; j++) mem[j] = '0;

    #2 reset = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_rw", mem_rw, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Max over 0..15, 4x4 map, zero-wait memory.
    for (int j = 0; j < 16; j++) mem[100 + j] = DW'(j);
    max_delay = 0;
    r0 = rq.size(); w0 = wq_a.size(); c0 = req_cycles; s0 = stab_err;
    run(1'b0, 1, 4, 100, 1000, cyc);
    chk("maxA_cycles", cyc, 42);
    chk("maxA_reads", rq.size() - r0, 16);
    chk("maxA_req_cycles", req_cycles - c0, 20);
    exp_a = '{5, 7, 13, 15};
    for (int j = 0; j < 4; j++)
      if (w0 + j < wq_d.size()) chk("maxA_const", wq_d[w0 + j], exp_a[j]);
    check_run("maxA", 1'b0, 1, 4, 100, 1000, w0);
    chk("maxA_stable", stab_err - s0, 0);

    // Average on the same map: floor of 10/4, 18/4, 42/4, 50/4.
    w0 = wq_a.size();
    run(1'b1, 1, 4, 100, 1010, cyc);
    exp_b = '{2, 4, 10, 12};
    for (int j = 0; j < 4; j++)
      if (w0 + j < wq_d.size()) chk("avgA_const", wq_d[w0 + j], exp_b[j]);
    check_run("avgA", 1'b1, 1, 4, 100, 1010, w0);

    // Negative window {-1,-2,-3,-4}.
    mem[200] = -16'sd1; mem[201] = -16'sd2; mem[202] = -16'sd3; mem[203] = -16'sd4;
    w0 = wq_a.size();
    run(1'b1, 1, 2, 200, 1100, cyc);
    chk("avgNeg_cycles", cyc, 12);
`ifdef POOL_RELU_EN
    if (w0 < wq_d.size()) chk("avgNeg_const", wq_d[w0], 0);
`else
    if (w0 < wq_d.size()) chk("avgNeg_const", wq_d[w0], -3);
`endif
    check_run("avgNeg", 1'b1, 1, 2, 200, 1100, w0);
    w0 = wq_a.size();
    run(1'b0, 1, 2, 200, 1101, cyc);
`ifdef POOL_RELU_EN
    if (w0 < wq_d.size()) chk("maxNeg_const", wq_d[w0], 0);
`else
    if (w0 < wq_d.size()) chk("maxNeg_const", wq_d[w0], -1);
`endif

    // S=5, two maps, random delays and stray acks.
    stray_en = 1'b1;
    max_delay = 5;
    for (int j = 300; j < 350; j++) mem[j] = DW'($urandom);
    for (int p = 0; p < 2; p++) begin
      m = 1'(p);
      r0 = rq.size(); w0 = wq_a.size(); s0 = stab_err;
      run(m, 2, 5, 300, 1200 + 16 * p, cyc);
      chk("s5_reads", rq.size() - r0, 32);
      if (r0 + 16 < rq.size()) chk("s5_map1_first", rq[r0 + 16], 325);
      viol = 0;
      for (int j = r0; j < rq.size(); j++) begin
        off = int'(rq[j]) - 300;
        if (off < 0 || off >= 50 || (off % 25) / 5 == 4 || off % 5 == 4) viol++;
      end
      chk("s5_trailing_reads", viol, 0);
      chk("s5_stable", stab_err - s0, 0);
      check_run("s5", m, 2, 5, 300, 1200 + 16 * p, w0);
    end

    // Degenerate runs: no maps, and maps smaller than one window.
    c0 = req_cycles; w0 = wq_a.size();
    run(1'b0, 0, 4, 100, 1300, cyc);
    chk("deg_cnt0_cycles", cyc, 2);
    run(1'b1, 3, 1, 100, 1300, cyc);
    chk("deg_small_cycles", cyc, 2);
    chk("deg_no_req", req_cycles - c0, 0);
    chk("deg_no_write", wq_a.size() - w0, 0);

    // Randomized runs against the reference.
    max_delay = 3;
    for (int j = 400; j < 600; j++) mem[j] = DW'($urandom);
    for (int t = 0; t < 6; t++) begin
      m   = 1'($urandom_range(0, 1));
      cnt = $urandom_range(1, 3);
      sz  = $urandom_range(2, 7);
      w0 = wq_a.size(); s0 = stab_err;
      run(m, cnt, sz, 400, 2000 + 64 * t, cyc);
      check_run("rand", m, cnt, sz, 400, 2000 + 64 * t, w0);
      chk("rand_stable", stab_err - s0, 0);
    end

    // Reset while a write waits for its ack.
    stray_en = 1'b0;
    max_delay = 0;
    hold_wr = 1'b1;
    @(negedge clk);
    mode = 1'b0; img_count = 8'd1; img_size = 8'd4;
    src_addr = 20'd100; dst_addr = 20'd1400; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!(mem_req === 1'b1 && mem_rw === 1'b0) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("rst_reach_wr", cnt < 200, 1);
    repeat (3) @(negedge clk);
    chk("wr_held", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_rw", mem_rw, 1);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    hold_wr = 1'b0;
    r0 = rq.size(); w0 = wq_a.size();
    run(1'b0, 1, 4, 100, 1400, cyc);
    chk("post_rst_cycles", cyc, 42);
    if (r0 < rq.size()) chk("post_rst_first_read", rq[r0], 100);
    check_run("post_rst", 1'b0, 1, 4, 100, 1400, w0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
